// File: rtl/pong_pkg.sv
// Shared encodings for the pong referee: bounce event codes, match FSM states
// and winner codes.
package pong_pkg;

  typedef enum logic [1:0] {
    BOUNCE_NONE   = 2'b00,
    BOUNCE_PADDLE = 2'b01,
    BOUNCE_WALL   = 2'b10,
    BOUNCE_GOAL   = 2'b11
  } bounce_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10
  } winner_t;

endpackage

// File: rtl/aabb_overlap.sv
// Axis-aligned rectangle overlap test with inclusive edges. Sums are one bit
// wider than the positions so a rectangle near the screen edge never wraps.
module aabb_overlap #(
  parameter int unsigned POS_W  = 10,
  parameter int unsigned SIZE_W = 8
) (
  input  logic [POS_W-1:0]  a_x,
  input  logic [POS_W-1:0]  a_y,
  input  logic [SIZE_W-1:0] a_w,
  input  logic [SIZE_W-1:0] a_h,
  input  logic [POS_W-1:0]  b_x,
  input  logic [POS_W-1:0]  b_y,
  input  logic [SIZE_W-1:0] b_w,
  input  logic [SIZE_W-1:0] b_h,
  output logic              overlap
);

  localparam int unsigned SUM_W = POS_W + 1;

  logic [SUM_W-1:0] a_x0, a_x1, a_y0, a_y1;
  logic [SUM_W-1:0] b_x0, b_x1, b_y0, b_y1;

  assign a_x0 = SUM_W'(a_x);
  assign a_y0 = SUM_W'(a_y);
  assign b_x0 = SUM_W'(b_x);
  assign b_y0 = SUM_W'(b_y);
  assign a_x1 = a_x0 + SUM_W'(a_w);
  assign a_y1 = a_y0 + SUM_W'(a_h);
  assign b_x1 = b_x0 + SUM_W'(b_w);
  assign b_y1 = b_y0 + SUM_W'(b_h);

  assign overlap = (a_x0 <= b_x1) && (b_x0 <= a_x1) && (a_y0 <= b_y1) && (b_y0 <= a_y1);

endmodule

// File: rtl/pong_referee.sv
// Per-frame collision evaluation and match FSM: emits one-shot bounce/serve
// events, keeps saturating scores and declares the winner.
module pong_referee
  import pong_pkg::*;
#(
  parameter int unsigned SCREEN_X     = 640,
  parameter int unsigned SCREEN_Y     = 480,
  parameter int unsigned MARGIN       = 5,
  parameter int unsigned POS_W        = 10,
  parameter int unsigned SIZE_W       = 8,
  parameter int unsigned SCORE_W      = 4,
  parameter int unsigned WIN_SCORE    = 9,
  parameter int unsigned SERVE_FRAMES = 60
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               frame_tick,
  input  logic               start,
  input  logic [POS_W-1:0]   ball_pos_x,
  input  logic [POS_W-1:0]   ball_pos_y,
  input  logic [SIZE_W-1:0]  ball_size_x,
  input  logic [SIZE_W-1:0]  ball_size_y,
  input  logic [POS_W-1:0]   paddle_1_pos_x,
  input  logic [POS_W-1:0]   paddle_1_pos_y,
  input  logic [SIZE_W-1:0]  paddle_1_size_x,
  input  logic [SIZE_W-1:0]  paddle_1_size_y,
  input  logic [POS_W-1:0]   paddle_2_pos_x,
  input  logic [POS_W-1:0]   paddle_2_pos_y,
  input  logic [SIZE_W-1:0]  paddle_2_size_x,
  input  logic [SIZE_W-1:0]  paddle_2_size_y,
  output logic [1:0]         bounce,
  output logic               serve,
  output logic [SCORE_W-1:0] score_player_1,
  output logic [SCORE_W-1:0] score_player_2,
  output logic [1:0]         winner,
  output logic [2:0]         state
);

  localparam int unsigned SUM_W = POS_W + 1;
  localparam int unsigned CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [SUM_W-1:0]   GoalRight = SUM_W'(SCREEN_X - MARGIN);
  localparam logic [SUM_W-1:0]   WallBot   = SUM_W'(SCREEN_Y - MARGIN);
  localparam logic [SUM_W-1:0]   Edge      = SUM_W'(MARGIN);
  localparam logic [CNT_W-1:0]   CntLast   = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WinScore  = SCORE_W'(WIN_SCORE);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             flag1_q, flag2_q;
  logic             hit1, hit2;
  logic             goal_r, goal_l, wall;
  logic [SUM_W-1:0] ball_r, ball_b;

  assign ball_r = SUM_W'(ball_pos_x) + SUM_W'(ball_size_x);
  assign ball_b = SUM_W'(ball_pos_y) + SUM_W'(ball_size_y);
  assign goal_r = ball_r >= GoalRight;
  assign goal_l = SUM_W'(ball_pos_x) <= Edge;
  assign wall   = (SUM_W'(ball_pos_y) <= Edge) || (ball_b >= WallBot);
  assign state  = state_q;

  aabb_overlap #(.POS_W(POS_W), .SIZE_W(SIZE_W)) u_hit1 (
    .a_x(ball_pos_x), .a_y(ball_pos_y), .a_w(ball_size_x), .a_h(ball_size_y),
    .b_x(paddle_1_pos_x), .b_y(paddle_1_pos_y), .b_w(paddle_1_size_x), .b_h(paddle_1_size_y),
    .overlap(hit1)
  );

  aabb_overlap #(.POS_W(POS_W), .SIZE_W(SIZE_W)) u_hit2 (
    .a_x(ball_pos_x), .a_y(ball_pos_y), .a_w(ball_size_x), .a_h(ball_size_y),
    .b_x(paddle_2_pos_x), .b_y(paddle_2_pos_y), .b_w(paddle_2_size_x), .b_h(paddle_2_size_y),
    .overlap(hit2)
  );

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (&s) ? s : s + 1'b1;
  endfunction

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      bounce         <= BOUNCE_NONE;
      serve          <= 1'b0;
      score_player_1 <= '0;
      score_player_2 <= '0;
      winner         <= WIN_NONE;
      cnt_q          <= '0;
      flag1_q        <= 1'b0;
      flag2_q        <= 1'b0;
    end else begin
      bounce <= BOUNCE_NONE;
      serve  <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_OVER: begin
          if (start) begin
            score_player_1 <= '0;
            score_player_2 <= '0;
            winner         <= WIN_NONE;
            cnt_q          <= '0;
            flag1_q        <= 1'b0;
            flag2_q        <= 1'b0;
            state_q        <= ST_SERVE;
          end
        end
        ST_SERVE: begin
          if (frame_tick) begin
            if (cnt_q == CntLast) begin
              serve   <= 1'b1;
              cnt_q   <= '0;
              state_q <= ST_PLAY;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_PLAY: begin
          if (frame_tick) begin
            // Flags re-arm once the ball has left the paddle on any tick.
            if (!hit1) flag1_q <= 1'b0;
            if (!hit2) flag2_q <= 1'b0;
            if (goal_r) begin
              score_player_1 <= sat_inc(score_player_1);
              bounce         <= BOUNCE_GOAL;
              state_q        <= ST_POINT;
            end else if (goal_l) begin
              score_player_2 <= sat_inc(score_player_2);
              bounce         <= BOUNCE_GOAL;
              state_q        <= ST_POINT;
            end else if (wall) begin
              bounce <= BOUNCE_WALL;
            end else if (hit1 && !flag1_q) begin
              bounce  <= BOUNCE_PADDLE;
              flag1_q <= 1'b1;
            end else if (hit2 && !flag2_q) begin
              bounce  <= BOUNCE_PADDLE;
              flag2_q <= 1'b1;
            end
          end
        end
        ST_POINT: begin
          if (score_player_1 == WinScore) begin
            winner  <= WIN_P1;
            state_q <= ST_OVER;
          end else if (score_player_2 == WinScore) begin
            winner  <= WIN_P2;
            state_q <= ST_OVER;
          end else begin
            flag1_q <= 1'b0;
            flag2_q <= 1'b0;
            state_q <= ST_SERVE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_referee.sv
// Directed bench for pong_referee: expected bounce/serve events are queued by
// the stimulus and consumed by an independent output monitor.
module tb_pong_referee;
  import pong_pkg::*;

  logic       clock, reset_n, frame_tick, start;
  logic [9:0] ball_pos_x, ball_pos_y, paddle_1_pos_x, paddle_1_pos_y;
  logic [9:0] paddle_2_pos_x, paddle_2_pos_y;
  logic [7:0] ball_size_x, ball_size_y, paddle_1_size_x, paddle_1_size_y;
  logic [7:0] paddle_2_size_x, paddle_2_size_y;
  logic [1:0] bounce, winner;
  logic       serve;
  logic [3:0] score_player_1, score_player_2;
  logic [2:0] state;

  int compared = 0;
  int mismatched = 0;
  int exp1 = 0;
  int exp2 = 0;
  logic [2:0] exp_q[$];  // {bounce, serve}

  pong_referee dut (
    .clock(clock), .reset_n(reset_n), .frame_tick(frame_tick), .start(start),
    .ball_pos_x(ball_pos_x), .ball_pos_y(ball_pos_y),
    .ball_size_x(ball_size_x), .ball_size_y(ball_size_y),
    .paddle_1_pos_x(paddle_1_pos_x), .paddle_1_pos_y(paddle_1_pos_y),
    .paddle_1_size_x(paddle_1_size_x), .paddle_1_size_y(paddle_1_size_y),
    .paddle_2_pos_x(paddle_2_pos_x), .paddle_2_pos_y(paddle_2_pos_y),
    .paddle_2_size_x(paddle_2_size_x), .paddle_2_size_y(paddle_2_size_y),
    .bounce(bounce), .serve(serve), .score_player_1(score_player_1),
    .score_player_2(score_player_2), .winner(winner), .state(state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Any visible event must match the head of the expectation queue.
  always @(negedge clock) begin
    if (reset_n && (bounce != 2'b00 || serve)) begin
      if (exp_q.size() == 0) check("unexpected_event", {bounce, serve}, 0);
      else check("event", {bounce, serve}, exp_q.pop_front());
    end
  end

  task automatic set_ball(input int x, input int y);
    ball_pos_x = 10'(x);
    ball_pos_y = 10'(y);
  endtask

  task automatic tick();
    @(posedge clock); #1 frame_tick = 1'b1;
    @(posedge clock); #1 frame_tick = 1'b0;
  endtask

  task automatic serve_ticks(input int n);
    repeat (n - 1) tick();
    exp_q.push_back(3'b001);
    tick();
    check("play_after_serve", state, ST_PLAY);
  endtask

  // Non-winning goal followed by a full re-serve.
  task automatic goal(input bit right);
    set_ball(right ? 636 : 3, 200);
    exp_q.push_back({BOUNCE_GOAL, 1'b0});
    tick();
    if (right) exp1++;
    else exp2++;
    check("goal_point_state", state, ST_POINT);
    check("goal_score_p1", score_player_1, exp1);
    check("goal_score_p2", score_player_2, exp2);
    set_ball(300, 200);
    @(posedge clock); #1;
    check("goal_serve_state", state, ST_SERVE);
    serve_ticks(60);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_state"}, state, ST_IDLE);
    check({tag, "_p1"}, score_player_1, 0);
    check({tag, "_p2"}, score_player_2, 0);
    check({tag, "_bounce"}, bounce, 0);
    check({tag, "_winner"}, winner, 0);
    check({tag, "_serve"}, serve, 0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; frame_tick = 1'b0;
    ball_size_x = 8; ball_size_y = 8;
    paddle_1_pos_x = 10;  paddle_1_pos_y = 80; paddle_1_size_x = 12; paddle_1_size_y = 60;
    paddle_2_pos_x = 620; paddle_2_pos_y = 0;  paddle_2_size_x = 12; paddle_2_size_y = 60;
    set_ball(300, 200);
    repeat (2) @(posedge clock);
    #1 check_reset_state("reset");
    reset_n = 1'b1;

    tick();  // ignored in IDLE
    check("idle_ignores_tick", state, ST_IDLE);
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    check("start_to_serve", state, ST_SERVE);
    serve_ticks(60);

    // Paddle 1 contact: one bounce while inside, re-arms after leaving.
    set_ball(20, 100);
    exp_q.push_back({BOUNCE_PADDLE, 1'b0});
    repeat (3) tick();
    set_ball(300, 200);
    tick();
    set_ball(20, 100);
    exp_q.push_back({BOUNCE_PADDLE, 1'b0});
    tick();
    set_ball(300, 200);
    tick();
    check("paddle_stays_play", state, ST_PLAY);

    // Wall beats paddle 2; the paddle flag must stay clear.
    set_ball(615, 3);
    exp_q.push_back({BOUNCE_WALL, 1'b0});
    tick();
    set_ball(615, 20);
    exp_q.push_back({BOUNCE_PADDLE, 1'b0});
    tick();
    set_ball(300, 200);
    tick();

    // Goal held for 5 ticks scores once.
    set_ball(636, 200);
    exp_q.push_back({BOUNCE_GOAL, 1'b0});
    tick();
    exp1 = 1;
    check("hold_point_state", state, ST_POINT);
    check("hold_score_p1", score_player_1, 1);
    @(posedge clock); #1;
    check("hold_serve_state", state, ST_SERVE);
    repeat (4) tick();
    check("hold_score_once", score_player_1, 1);
    check("hold_still_serve", state, ST_SERVE);
    set_ball(300, 200);
    serve_ticks(56);

    goal(1'b0);
    for (int g = 0; g < 7; g++) goal(1'b1);
    check("pre_win_p1", score_player_1, 8);

    // Winning goal.
    set_ball(636, 200);
    exp_q.push_back({BOUNCE_GOAL, 1'b0});
    tick();
    check("win_point_state", state, ST_POINT);
    check("win_score", score_player_1, 9);
    @(posedge clock); #1;
    check("win_over_state", state, ST_OVER);
    check("win_winner", winner, WIN_P1);
    repeat (3) tick();
    check("over_hold_p1", score_player_1, 9);
    check("over_hold_p2", score_player_2, 1);
    check("over_hold_state", state, ST_OVER);
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    check("restart_state", state, ST_SERVE);
    check("restart_p1", score_player_1, 0);
    check("restart_p2", score_player_2, 0);
    check("restart_winner", winner, WIN_NONE);
    exp1 = 0; exp2 = 0;
    set_ball(300, 200);
    serve_ticks(60);

    // Reach 3:2 in PLAY, then reset.
    goal(1'b1); goal(1'b1); goal(1'b1); goal(1'b0); goal(1'b0);
    check("mid_p1", score_player_1, 3);
    check("mid_p2", score_player_2, 2);
    @(posedge clock); #1 reset_n = 1'b0;
    @(posedge clock); #1;
    check_reset_state("midplay_reset");
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1 check("pending_events", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
